// File: rtl/am_demod_pkg.sv
// Shared types and helpers for the AM envelope demodulator.
// No logic of its own: FSM state encoding, audio rails and the 16-bit saturator.
// No flow control here; users decide when sat16 results are registered.
package am_demod_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ABS,
    MAG,
    DCB,
    OUT
  } state_t;

  localparam logic signed [15:0] AUDIO_MAX = 16'sh7fff;
  localparam logic signed [15:0] AUDIO_MIN = 16'sh8000;

  // Clamp a wide signed value onto the 16-bit audio rails.
  function automatic logic signed [15:0] sat16(input logic signed [31:0] v);
    if (v > 32'(AUDIO_MAX)) begin
      return AUDIO_MAX;
    end
    if (v < 32'(AUDIO_MIN)) begin
      return AUDIO_MIN;
    end
    return v[15:0];
  endfunction

endpackage

// File: rtl/am_mag_est.sv
// Alpha-max-beta-min magnitude estimate of a captured I/Q pair, two register stages.
// Latency: abs_en cycle loads |I|,|Q|; mag_en cycle (next) loads the magnitude.
// No backpressure: stages advance only on the enables driven by the owning FSM.
module am_mag_est
  import am_demod_pkg::*;
#(
  parameter int IN_BITS = 16
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      abs_en,
  input  logic                      mag_en,
  input  logic signed [IN_BITS-1:0] i_cap,
  input  logic signed [IN_BITS-1:0] q_cap,
  output logic        [IN_BITS-1:0] mag
);

  localparam int MW = IN_BITS + 1;
  localparam logic signed [IN_BITS-1:0] IN_MIN = {1'b1, {(IN_BITS-1){1'b0}}};

  // |x| with the most negative code pinned to the most positive one, so the
  // result always fits in IN_BITS-1 unsigned bits.
  function automatic logic [IN_BITS-2:0] abs_sat(input logic signed [IN_BITS-1:0] x);
    logic signed [IN_BITS-1:0] n;
    if (x == IN_MIN) begin
      return '1;
    end
    n = x[IN_BITS-1] ? -x : x;
    return n[IN_BITS-2:0];
  endfunction

  logic [IN_BITS-2:0] a_q;
  logic [IN_BITS-2:0] b_q;
  logic [IN_BITS-2:0] mx;
  logic [IN_BITS-2:0] mn;
  logic [MW-1:0]      m;
  logic [MW-1:0]      m_q;

  assign mx = (a_q >= b_q) ? a_q : b_q;
  assign mn = (a_q >= b_q) ? b_q : a_q;

  // max*(15/16) + min*(15/32); one extra bit covers the sum of both terms.
  assign m = MW'(mx) - MW'(mx >> 4) + MW'(mn >> 1) - MW'(mn >> 5);

  // Halving keeps the magnitude below 2^(IN_BITS-1), i.e. non-negative as signed.
  assign mag = IN_BITS'(m_q >> 1);

  // Two-stage pipeline: absolute values, then the combined magnitude.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_q <= '0;
      b_q <= '0;
      m_q <= '0;
    end else begin
      if (abs_en) begin
        a_q <= abs_sat(i_cap);
        b_q <= abs_sat(q_cap);
      end
      if (mag_en) begin
        m_q <= m;
      end
    end
  end

endmodule

// File: rtl/am_envelope_demod.sv
// AM envelope demodulator: |I+jQ| estimate, optional DC blocker (AM_ENVELOPE_DEMOD_DCBLOCK_EN), gain, sat16.
// Latency: in_tick in cycle N -> audio_out/out_tick in cycle N+4, fixed in both builds.
// No backpressure: in_tick during ABS/MAG/DCB drops the sample and pulses overrun next cycle.
module am_envelope_demod
  import am_demod_pkg::*;
#(
  parameter int IN_BITS    = 16,
  parameter int ACC_BITS   = 24,
  parameter int DC_SHIFT   = 8,
  parameter int GAIN_SHIFT = 0
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic signed [IN_BITS-1:0] i_in,
  input  logic signed [IN_BITS-1:0] q_in,
  input  logic                      in_tick,
  output logic signed [15:0]        audio_out,
  output logic                      out_tick,
  output logic                      busy,
  output logic                      overrun
);

  state_t state;
  state_t state_nxt;

  logic                       accept;
  logic signed [IN_BITS-1:0]  i_cap;
  logic signed [IN_BITS-1:0]  q_cap;
  logic        [IN_BITS-1:0]  mag;
  logic signed [ACC_BITS-1:0] mag_ext;
  logic signed [ACC_BITS-1:0] y;
  logic signed [31:0]         y_gain;

  // A new pair is only taken while the datapath is free (IDLE) or finishing (OUT).
  assign accept = in_tick && ((state == IDLE) || (state == OUT));

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and busy decode.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (in_tick) begin
          state_nxt = ABS;
        end
      end
      ABS: begin
        busy      = 1'b1;
        state_nxt = MAG;
      end
      MAG: begin
        busy      = 1'b1;
        state_nxt = DCB;
      end
      DCB: begin
        busy      = 1'b1;
        state_nxt = OUT;
      end
      OUT: begin
        state_nxt = in_tick ? ABS : IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // I/Q capture on accepted ticks.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      i_cap <= '0;
      q_cap <= '0;
    end else if (accept) begin
      i_cap <= i_in;
      q_cap <= q_in;
    end
  end

  am_mag_est #(
    .IN_BITS (IN_BITS)
  ) u_mag_est (
    .CLK    (CLK),
    .RST    (RST),
    .abs_en (state == ABS),
    .mag_en (state == MAG),
    .i_cap  (i_cap),
    .q_cap  (q_cap),
    .mag    (mag)
  );

  assign mag_ext = $signed(ACC_BITS'(mag));

`ifdef AM_ENVELOPE_DEMOD_DCBLOCK_EN
  logic signed [ACC_BITS-1:0] mag_prev;
  logic signed [ACC_BITS-1:0] y_prev;

  // First-order high-pass: differentiate, then leaky-integrate with pole 1-2^-DC_SHIFT.
  assign y = mag_ext - mag_prev + y_prev - (y_prev >>> DC_SHIFT);

  // Filter history advances once per accepted sample, in its DCB cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mag_prev <= '0;
      y_prev   <= '0;
    end else if (state == DCB) begin
      mag_prev <= mag_ext;
      y_prev   <= y;
    end
  end
`else
  // Without the blocker the envelope (including carrier DC) goes straight out.
  assign y = mag_ext;
`endif

  assign y_gain = 32'(y) <<< GAIN_SHIFT;

  // Output register: audio updates leaving DCB so it is valid with out_tick in OUT.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      audio_out <= '0;
      out_tick  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_tick <= (state == DCB);
      overrun  <= in_tick && busy;
      if (state == DCB) begin
        audio_out <= sat16(y_gain);
      end
    end
  end

endmodule
